clk_freq_monitor: RTL and testbench



---
 rtl/clk_mon_pkg.sv | 24 ++
 rtl/clk_freq_monitor_sync_edge_det.sv | 30 +++
 rtl/clk_freq_monitor.sv | 125 ++++++++++++
 tb/tb_clk_freq_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Purpose: shared types and helpers for the clock frequency monitor.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mon_state_t;

  // True when cnt lies within [exp_edges-tol, exp_edges+tol].
  // The lower bound clamps to 0 so a large tolerance cannot wrap around.
  function automatic logic in_tolerance(input logic [31:0] cnt,
                                        input logic [31:0] exp_edges,
                                        input logic [31:0] tol);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = (tol > exp_edges) ? 33'd0 : {1'b0, exp_edges - tol};
    hi = {1'b0, exp_edges} + {1'b0, tol};
    return ({1'b0, cnt} >= lo) && ({1'b0, cnt} <= hi);
  endfunction

endpackage

// File: rtl/clk_freq_monitor_sync_edge_det.sv
// Purpose: 2-flop synchronizer plus rising-edge detector for an async strobe.
// Latency: input rise -> edge_pulse high 2 clk_in1 edges later, one cycle wide.
// Backpressure: none; free-running, pulses are never held off.
module sync_edge_det (
  input  logic clk_in1,
  input  logic resetn,
  input  logic async_in,
  output logic edge_pulse
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronize the async input and keep one extra stage for edge detection.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;

endmodule

// File: rtl/clk_freq_monitor.sv
// Purpose: counts monitored-clock rising edges per reference window and tracks lock.
// Latency: mon_clk rise counted 3 clk_in1 cycles later; window_done 1 cycle after window close.
// Backpressure: none; results are overwritten each window, window_done is a bare pulse.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int EXP_EDGES     = 512,
  parameter int TOL           = 2,
  parameter int LOCK_WINDOWS  = 4,
  parameter int CNT_W         = $clog2(WINDOW_CYCLES + 1)
) (
  input  logic             clk_in1,
  input  logic             resetn,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clr_lost,
  output logic             locked,
  output logic             window_done,
  output logic [CNT_W-1:0] edge_count,
  output logic             lost_lock
);

  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINDOWS - 1);

  mon_state_t        state;
  logic [CNT_W-1:0]  window_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  final_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              edge_pulse;
  logic              window_good;

  sync_edge_det u_sync_edge_det (
    .clk_in1    (clk_in1),
    .resetn     (resetn),
    .async_in   (mon_clk),
    .edge_pulse (edge_pulse)
  );

  // Running count including this cycle's edge; saturates so it never wraps.
  always_comb begin
    final_cnt = edge_cnt;
    if (edge_pulse && (edge_cnt != CNT_MAX)) begin
      final_cnt = edge_cnt + CNT_W'(1);
    end
  end

  assign window_good = in_tolerance(32'(final_cnt), 32'(EXP_EDGES), 32'(TOL));

  // Window sequencing, lock qualification and sticky loss-of-lock flag.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      window_cnt  <= '0;
      edge_cnt    <= '0;
      good_cnt    <= '0;
      locked      <= 1'b0;
      window_done <= 1'b0;
      edge_count  <= '0;
      lost_lock   <= 1'b0;
    end else begin
      window_done <= 1'b0;
      // A set later in this block overrides the clear.
      if (clr_lost) begin
        lost_lock <= 1'b0;
      end
      case (state)
        IDLE: begin
          window_cnt <= '0;
          edge_cnt   <= '0;
          good_cnt   <= '0;
          locked     <= 1'b0;
          if (enable) begin
            state <= ACQUIRE;
          end
        end
        ACQUIRE, LOCKED: begin
          if (!enable) begin
            // Partial window is discarded; edge_count keeps the last result.
            state      <= IDLE;
            locked     <= 1'b0;
            window_cnt <= '0;
            edge_cnt   <= '0;
            good_cnt   <= '0;
          end else if (window_cnt == WIN_LAST) begin
            window_cnt  <= '0;
            edge_cnt    <= '0;
            edge_count  <= final_cnt;
            window_done <= 1'b1;
            if (state == LOCKED) begin
              if (!window_good) begin
                state     <= ACQUIRE;
                locked    <= 1'b0;
                good_cnt  <= '0;
                lost_lock <= 1'b1;
              end
            end else if (window_good) begin
              if (good_cnt == GOOD_LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end else begin
              good_cnt <= '0;
            end
          end else begin
            window_cnt <= window_cnt + CNT_W'(1);
            edge_cnt   <= final_cnt;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Purpose: self-checking bench for clk_freq_monitor with a window scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_freq_monitor;

  localparam int WC   = 16;
  localparam int EXP  = 8;
  localparam int TOLR = 1;
  localparam int LW   = 2;
  localparam int CW   = $clog2(WC + 1);

  logic          clk_in1  = 1'b0;
  logic          resetn   = 1'b0;
  logic          mon_clk  = 1'b0;
  logic          enable   = 1'b0;
  logic          clr_lost = 1'b0;
  logic          locked;
  logic          window_done;
  logic [CW-1:0] edge_count;
  logic          lost_lock;

  clk_freq_monitor #(
    .WINDOW_CYCLES (WC),
    .EXP_EDGES     (EXP),
    .TOL           (TOLR),
    .LOCK_WINDOWS  (LW)
  ) u_dut (
    .clk_in1     (clk_in1),
    .resetn      (resetn),
    .mon_clk     (mon_clk),
    .enable      (enable),
    .clr_lost    (clr_lost),
    .locked      (locked),
    .window_done (window_done),
    .edge_count  (edge_count),
    .lost_lock   (lost_lock)
  );

  always #5 clk_in1 = ~clk_in1;

  typedef struct {
    int   cnt;
    logic lk;
    logic lost;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Edge-arrival model: a rise driven before posedge k is counted at posedge k+2.
  logic mon_prev = 1'b0;
  logic r1 = 1'b0;
  logic r2 = 1'b0;
  int   acc = 0;
  int   last_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one clk_in1 cycle of stimulus and advance the arrival model.
  task automatic tick(input logic mon, input logic en, input bit in_win, input logic clr);
    logic rise;
    logic landed;
    @(negedge clk_in1);
    mon_clk  = mon;
    enable   = en;
    clr_lost = clr;
    rise     = mon & ~mon_prev;
    mon_prev = mon;
    landed   = r2;
    r2       = r1;
    r1       = rise;
    if (in_win && landed) acc++;
  endtask

  // Drive one full measurement window; pat[i] is mon_clk for window cycle i.
  task automatic run_window(input logic [15:0] pat, input logic exp_lk,
                            input logic exp_lost, input int clr_at);
    acc = 0;
    for (int i = 0; i < WC; i++) begin
      tick(pat[i], 1'b1, 1'b1, logic'(i == clr_at));
    end
    sb_q.push_back('{acc, exp_lk, exp_lost});
    last_cnt = acc;
  endtask

  // Score every window close against the queued expectation.
  always @(posedge clk_in1) begin
    #1;
    if (window_done) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_window_done", 32'(window_done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("win_edge_count", 32'(edge_count), 32'(mon_e.cnt));
        check_eq("win_locked", 32'(locked), 32'(mon_e.lk));
        check_eq("win_lost_lock", 32'(lost_lock), 32'(mon_e.lost));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in1);
    #1;
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_window_done", 32'(window_done), 32'd0);
    check_eq("rst_edge_count", 32'(edge_count), 32'd0);
    check_eq("rst_lost_lock", 32'(lost_lock), 32'd0);
    @(negedge clk_in1);
    resetn = 1'b1;

    // mon_clk = clk_in1/2 already running when enable rises
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_window(16'h5555, 1'b0, 1'b0, -1);
    run_window(16'h5555, 1'b1, 1'b0, -1);
    run_window(16'h5555, 1'b1, 1'b0, -1);

    // Disable mid-window while locked: no window_done, edge_count held, no lost_lock
    for (int i = 0; i < 5; i++) tick(logic'(i % 2 == 0), 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_in1);
    #1;
    check_eq("dis_locked", 32'(locked), 32'd0);
    check_eq("dis_edge_count", 32'(edge_count), 32'(last_cnt));
    check_eq("dis_lost_lock", 32'(lost_lock), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Relock at /2, then mon_clk stuck low: lock drops, lost_lock sticks
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_window(16'h5555, 1'b0, 1'b0, -1);
    run_window(16'h5555, 1'b1, 1'b0, -1);
    run_window(16'h0000, 1'b0, 1'b1, -1);
    run_window(16'h0000, 1'b0, 1'b1, -1);

    // 7 edges (clr_lost pulsed), 6 edges breaks the run, then 7,7 locks
    run_window(16'h1555, 1'b0, 1'b0, 3);
    run_window(16'h0555, 1'b0, 1'b0, -1);
    run_window(16'h1555, 1'b0, 1'b0, -1);
    run_window(16'h1555, 1'b1, 1'b0, -1);

    // Edge arriving on the last window cycle belongs to that window
    run_window(16'h2555, 1'b1, 1'b0, -1);
    run_window(16'h1555, 1'b1, 1'b0, -1);

    // /4 clock from a fresh enable: 4 edges per window, never locks
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_window(16'h1111, 1'b0, 1'b0, -1);
    run_window(16'h1111, 1'b0, 1'b0, -1);
    run_window(16'h1111, 1'b0, 1'b0, -1);

    // Lock again, then async reset mid-window
    run_window(16'h1555, 1'b0, 1'b0, -1);
    run_window(16'h1555, 1'b1, 1'b0, -1);
    for (int i = 0; i < 6; i++) tick(logic'(i % 2 == 0), 1'b1, 1'b1, 1'b0);
    @(negedge clk_in1);
    mon_clk = 1'b0;
    enable  = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check_eq("arst_locked", 32'(locked), 32'd0);
    check_eq("arst_edge_count", 32'(edge_count), 32'd0);
    check_eq("arst_window_done", 32'(window_done), 32'd0);
    check_eq("arst_lost_lock", 32'(lost_lock), 32'd0);
    mon_prev = 1'b0;
    r1       = 1'b0;
    r2       = 1'b0;
    @(negedge clk_in1);
    resetn = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_window(16'h5555, 1'b0, 1'b0, -1);
    run_window(16'h5555, 1'b1, 1'b0, -1);

    repeat (3) @(posedge clk_in1);
    #2;
    check_eq("sb_pending", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
